// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (I/D), memory and hazard-unit signals of the shared memory arbiter.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_rvalid;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  err;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  i_busy;
   logic                  d_busy;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      output i_rvalid, i_rdata, d_rvalid, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata,
             i_busy, d_busy
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      input  i_rvalid, i_rdata, d_rvalid, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata,
             i_busy, d_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbitration of one single-port memory between instruction fetch (I)
// and data cache (D), with a response timeout that returns an error pulse.
module mem_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   state_t                state_q;
   logic                  owner_q;
   logic                  prio_q;
   logic [7:0]            cnt_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  i_rvalid_q;
   logic                  d_rvalid_q;
   logic [DATA_WIDTH-1:0] i_rdata_q;
   logic [DATA_WIDTH-1:0] d_rdata_q;
   logic                  err_q;
   logic                  owner_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   // owner 1 = D; prio_q names the side that wins the next tie, so D wins the first one
   assign owner_d = (bus.i_req & bus.d_req) ? prio_q : bus.d_req;
   assign rdata_d = (bus.mem_rvalid & ~mem_we_q) ? bus.mem_rdata : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         prio_q      <= 1'b1;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.i_req | bus.d_req) begin
               owner_q     <= owner_d;
               prio_q      <= ~owner_d;
               mem_req_q   <= 1'b1;
               mem_we_q    <= owner_d & bus.d_we;
               mem_addr_q  <= owner_d ? bus.d_addr : bus.i_addr;
               mem_wdata_q <= owner_d ? bus.d_wdata : '0;
               state_q     <= ISSUE;
            end
            ISSUE: begin
               mem_req_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= WAIT;
            end
            WAIT: if (bus.mem_rvalid || cnt_q == CNT_LAST) begin
               if (owner_q) begin
                  d_rvalid_q <= 1'b1;
                  d_rdata_q  <= rdata_d;
               end else begin
                  i_rvalid_q <= 1'b1;
                  i_rdata_q  <= rdata_d;
               end
               err_q   <= ~bus.mem_rvalid;
               state_q <= RESP;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
            RESP: begin
               i_rvalid_q <= 1'b0;
               d_rvalid_q <= 1'b0;
               err_q      <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_rvalid  = i_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.err       = err_q;
   assign bus.i_busy    = bus.i_req & ~i_rvalid_q;
   assign bus.d_busy    = bus.d_req & ~d_rvalid_q;
endmodule
